// File: rtl/sys_bus_arbiter_if.sv
// sys_bus_arbiter_if
//   Request/grant bundle between the two sys_bus masters and the arbiter.
//   Signals:
//     m0_req, m0_lock  master0 (CPU) request and no-preempt lock
//     m1_req, m1_lock  master1 (DMA/debug) request and no-preempt lock
//     grant0, grant1   registered bus ownership, never both high
//     hold_flag_m0/m1  requester stall (req & ~grant)
//     busy             either master owns the bus
//   Modports:
//     master  requester side: drives req/lock, observes grant/hold/busy
//     slave   arbiter side:   observes req/lock, drives grant/hold/busy
interface sys_bus_arbiter_if;
   logic m0_req;
   logic m0_lock;
   logic m1_req;
   logic m1_lock;
   logic grant0;
   logic grant1;
   logic hold_flag_m0;
   logic hold_flag_m1;
   logic busy;

   modport master (
      output m0_req, m0_lock, m1_req, m1_lock,
      input  grant0, grant1, hold_flag_m0, hold_flag_m1, busy
   );

   modport slave (
      input  m0_req, m0_lock, m1_req, m1_lock,
      output grant0, grant1, hold_flag_m0, hold_flag_m1, busy
   );
endinterface

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter
//   Two-master sys_bus arbiter (master0 = CPU, master1 = DMA/debug).
//   One owner at a time, per-owner lock against preemption, and a tenure
//   limit so a waiting master gets the bus after MAX_TENURE owned cycles.
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous active-high reset
//     bus   sys_bus_arbiter_if.slave (req/lock in, grant/hold/busy out)
//   Parameters:
//     MAX_TENURE  consecutive owned cycles allowed while the other waits (>=2)
//     TENURE_W    tenure counter width, must hold MAX_TENURE-1
//   Build option:
//     ARB_ROUND_ROBIN_EN  defined: IDLE tie goes to the master that did not
//                         own last (m0 first after reset).
//                         undefined: IDLE tie always goes to m1.
module sys_bus_arbiter #(
   parameter int MAX_TENURE = 8,
   parameter int TENURE_W   = 4
) (
   input logic             clk,
   input logic             rst,
   sys_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

   localparam logic [TENURE_W-1:0] TEN_SAT = TENURE_W'(MAX_TENURE - 1);

   state_e              state_q, state_d;
   logic [TENURE_W-1:0] tenure_q, tenure_d;
   logic                tie_to_m0;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = master1 owned last; reset value makes the first tie go to m0
   logic last_owner_q, last_owner_d;

   assign tie_to_m0 = last_owner_q;

   always_comb begin
      last_owner_d = last_owner_q;
      if (state_d == OWN0 && state_q != OWN0) last_owner_d = 1'b0;
      if (state_d == OWN1 && state_q != OWN1) last_owner_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) last_owner_q <= 1'b1;
      else     last_owner_q <= last_owner_d;
   end
`else
   assign tie_to_m0 = 1'b0;
`endif

   // Next state and tenure. Tenure counts cycles the other master has been
   // waiting while we own; it resets whenever the waiter goes away.
   always_comb begin
      state_d  = state_q;
      tenure_d = tenure_q;
      case (state_q)
         IDLE: begin
            if (bus.m0_req && bus.m1_req) state_d = tie_to_m0 ? OWN0 : OWN1;
            else if (bus.m0_req)          state_d = OWN0;
            else if (bus.m1_req)          state_d = OWN1;
         end
         OWN0: begin
            if (!bus.m0_req)
               state_d = bus.m1_req ? OWN1 : IDLE;
            else if (bus.m1_req && !bus.m0_lock && tenure_q == TEN_SAT)
               state_d = OWN1;
            else if (!bus.m1_req)
               tenure_d = '0;
            else if (tenure_q != TEN_SAT)
               tenure_d = tenure_q + 1'b1;
         end
         OWN1: begin
            if (!bus.m1_req)
               state_d = bus.m0_req ? OWN0 : IDLE;
            else if (bus.m0_req && !bus.m1_lock && tenure_q == TEN_SAT)
               state_d = OWN0;
            else if (!bus.m0_req)
               tenure_d = '0;
            else if (tenure_q != TEN_SAT)
               tenure_d = tenure_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) tenure_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tenure_q <= '0;
      end else begin
         state_q  <= state_d;
         tenure_q <= tenure_d;
      end
   end

   assign bus.grant0       = (state_q == OWN0);
   assign bus.grant1       = (state_q == OWN1);
   assign bus.hold_flag_m0 = bus.m0_req & ~bus.grant0;
   assign bus.hold_flag_m1 = bus.m1_req & ~bus.grant1;
   assign bus.busy         = bus.grant0 | bus.grant1;

endmodule
